fs_stage: RTL and testbench
===========================

// Module: fs_stage
// PURPOSE
//  Instruction-fetch (IF) stage between pre-IF and ID. Accepts one PC+exception tag per
//  ps_to_fs handshake and waits for the matching inst_sram data_ok (requests complete in
//  order). Latches rdata and presents {ex flags, pc, inst} to ID. On a flush it discards
//  responses to requests that are still in flight.
// PARAMETERS
//  CANCEL_W   2   width of the outstanding-request and discard counters (max 2**CANCEL_W-1 in flight)
// PORTS
//  clk               in   1   clock; all state updates on posedge
//  reset             in   1   synchronous, active-high
//  ps_to_fs_valid    in   1   pre-IF entry valid
//  ps_to_fs_bus      in   35  {pc_adel, tlb_miss, tlb_invalid, pc[31:0]}
//  fs_allowin        out  1   IF can take an entry this cycle
//  inst_sram_data_ok in   1   one in-order response for a previously accepted request
//  inst_sram_rdata   in   32  instruction word, valid with data_ok
//  ds_allowin        in   1   ID can accept
//  fs_to_ds_valid    out  1   entry ready for ID
//  fs_to_ds_bus      out  67  {pc_adel, tlb_miss, tlb_invalid, pc[31:0], inst[31:0]}
//  handle_exc        in   1   flush: exception taken
//  handle_eret       in   1   flush: eret
//  pipe_flush        in   1   flush: refetch
// BEHAVIOUR
//  - flush = handle_exc | handle_eret | pipe_flush.
//  - Reset: fs_valid=0, inst_ok=0, outstanding=0, discard=0, bus register=0.
//    Outputs after reset: fs_allowin=1, fs_to_ds_valid=0.
//  - Entry ex = any of the 3 flag bits. Exception entries issue no request: inst_ok is set
//    on accept and inst=32'h0.
//  - issue = ps_to_fs_valid & fs_allowin & !ex. Issuing increments outstanding.
//    Every data_ok decrements outstanding. Both in the same cycle: no change.
//  - data_ok with discard!=0: decrement discard, drop rdata.
//    data_ok with discard==0: fill the current entry (inst<=rdata, inst_ok<=1).
//  - fs_ready_go = inst_ok | (data_ok & discard==0)  (rdata bypasses same-cycle to ID).
//  - fs_to_ds_valid = fs_valid & fs_ready_go & !flush.
//  - fs_allowin = !fs_valid | (fs_ready_go & ds_allowin).
//  - Accept: fs_valid<=ps_to_fs_valid, bus<=ps_to_fs_bus, inst_ok<=ex.
//  - Flush cycle: fs_valid<=0, inst_ok<=0.
//    discard <= outstanding (after this cycle's inc/dec) minus 1 if this cycle's data_ok is already counted.
//    Flush has priority over accept; no entry is captured that cycle.
//  - Flush while discard!=0: discard accumulates the new in-flight count; it never drops below 0.
//  - outstanding never exceeds 2**CANCEL_W-1. The pre-IF limit of one fs slot guarantees
//    this; a simulation assertion flags overflow.
//  - Latency: fs_to_ds_valid rises in the data_ok cycle (zero bubble). Holds stable while ds_allowin=0.
// CONFIGURATION
//  FS_PERF_CNT_EN defined: adds output fs_stall_cnt[31:0] (reset 0).
//    Counts cycles with fs_valid & !fs_ready_go & !flush.
//    Saturates at 32'hffffffff.
//  FS_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Accept pc=bfc00000 (flags 0), data_ok+rdata=3c1d0001 two cycles later, ds_allowin=1
//    -> fs_to_ds_valid=1 in the data_ok cycle, bus={3'b0,bfc00000,3c1d0001}.
//  2 Same as 1 with ds_allowin=0 for 3 cycles
//    -> valid held, inst stable, fs_allowin=0 until ds_allowin=1.
//  3 Accept pc=bfc00002 (adel=1)
//    -> next cycle fs_to_ds_valid=1 with inst=0; no data_ok expected; outstanding stays 0.
//  4 Issue at bfc00000, pipe_flush before data_ok, then accept bfc00380 and return data_ok twice
//    (AAAA then BBBB) -> first dropped; bfc00380 leaves with inst=BBBB.
//  5 Flush in the same cycle as data_ok for the current entry
//    -> response consumed, discard=0, no entry to ID, next response fills the new entry.
//  6 FS_PERF_CNT_EN: 4 cycles waiting for data_ok -> fs_stall_cnt=4; a flush cycle is not counted.

Source files
------------

// File: rtl/fs_stage.sv
// -----------------------------------------------------------------------------
// fs_stage : instruction-fetch stage sitting between pre-IF and ID.
//
// Holds one fetch entry (exception flags + PC). The instruction SRAM request
// for that entry is issued by pre-IF when the entry is accepted here; this
// stage tracks how many requests are in flight and, after a flush, how many
// of those responses belong to squashed entries and must be thrown away.
// A live response is forwarded to ID in the same cycle it arrives and is
// also latched in case ID stalls.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   ps_to_fs_valid/bus  entry from pre-IF: {pc_adel, tlb_miss, tlb_invalid, pc}
//   fs_allowin          this stage can take an entry this cycle
//   inst_sram_data_ok   one in-order response for an earlier request
//   inst_sram_rdata     instruction word qualified by data_ok
//   ds_allowin          ID can take an entry
//   fs_to_ds_valid/bus  entry to ID: {flags, pc, inst}
//   handle_exc, handle_eret, pipe_flush   flush sources (any one flushes)
//   fs_stall_cnt        cycles spent waiting on the SRAM (only with the macro)
//
// Configuration
//   FS_PERF_CNT_EN  when defined, adds the saturating fs_stall_cnt output.
// -----------------------------------------------------------------------------
module fs_stage #(
  parameter int CANCEL_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps_to_fs_valid,
  input  logic [34:0] ps_to_fs_bus,
  output logic        fs_allowin,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [66:0] fs_to_ds_bus,
  input  logic        handle_exc,
  input  logic        handle_eret,
  input  logic        pipe_flush
`ifdef FS_PERF_CNT_EN
  ,
  output logic [31:0] fs_stall_cnt
`endif
);

  localparam logic [CANCEL_W-1:0] CNT_ONE = 1;
  localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

  logic                fs_valid;
  logic                inst_ok;
  logic [34:0]         fs_bus;
  logic [31:0]         fs_inst;
  logic [CANCEL_W-1:0] outstanding;
  logic [CANCEL_W-1:0] discard;
  logic [CANCEL_W-1:0] outstanding_next;
  logic [CANCEL_W-1:0] discard_next;

  logic flush;
  logic entry_ex;
  logic issue;
  logic resp_live;
  logic fs_ready_go;

  assign flush    = handle_exc | handle_eret | pipe_flush;
  assign entry_ex = |ps_to_fs_bus[34:32];

  // A response is live only when no squashed responses are still ahead of it.
  assign resp_live   = inst_sram_data_ok & (discard == '0);
  assign fs_ready_go = inst_ok | resp_live;

  assign fs_allowin     = !fs_valid | (fs_ready_go & ds_allowin);
  assign fs_to_ds_valid = fs_valid & fs_ready_go & !flush;

  // Exception entries never reach the SRAM, so they do not count as issued.
  assign issue = ps_to_fs_valid & fs_allowin & !entry_ex;

  // Latched word once it has arrived, otherwise the response bypasses straight through.
  assign fs_to_ds_bus = {fs_bus, inst_ok ? fs_inst : inst_sram_rdata};

  // NOTE: every signal gets a default at the top of an always_comb so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    outstanding_next = outstanding;
    discard_next     = discard;

    if (issue && !inst_sram_data_ok) begin
      outstanding_next = outstanding + CNT_ONE;
    end else if (!issue && inst_sram_data_ok) begin
      outstanding_next = outstanding - CNT_ONE;
    end

    // On a flush everything still in flight after this cycle is stale, including
    // any request issued this very cycle; the response consumed now is already
    // removed from outstanding_next, so discard cannot go negative.
    if (flush) begin
      discard_next = outstanding_next;
    end else if (inst_sram_data_ok && discard != '0) begin
      discard_next = discard - CNT_ONE;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid    <= 1'b0;
      inst_ok     <= 1'b0;
      fs_bus      <= '0;
      fs_inst     <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      discard     <= discard_next;

      if (flush) begin
        // Flush wins over accept: the slot empties and nothing is captured.
        fs_valid <= 1'b0;
        inst_ok  <= 1'b0;
      end else if (fs_allowin) begin
        fs_valid <= ps_to_fs_valid;
        if (ps_to_fs_valid) begin
          fs_bus  <= ps_to_fs_bus;
          fs_inst <= '0;
          inst_ok <= entry_ex;
        end
      end else if (resp_live) begin
        // ID is stalled: keep the word so the entry stays stable.
        fs_inst <= inst_sram_rdata;
        inst_ok <= 1'b1;
      end
    end
  end

`ifdef FS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_stall_cnt <= '0;
    end else if (fs_valid && !fs_ready_go && !flush && fs_stall_cnt != 32'hffff_ffff) begin
      fs_stall_cnt <= fs_stall_cnt + 32'd1;
    end
  end
`endif

  // Pre-IF only ever has one slot's worth of requests pending per entry, so the
  // counter can never wrap; a wrap or an unexpected response is a protocol bug.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(issue && !inst_sram_data_ok && outstanding == CNT_MAX));
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    !(inst_sram_data_ok && !issue && outstanding == '0));

endmodule

// File: tb/tb_fs_stage.sv
// -----------------------------------------------------------------------------
// tb_fs_stage : self-checking bench for fs_stage.
// Directed scenarios for the documented fetch behaviours, then a randomized run
// compared against a queue-based model: each in-flight request is a queue slot
// tagged live or squashed, and responses pop the queue in order.
// -----------------------------------------------------------------------------
module tb_fs_stage;

  logic        clk;
  logic        reset;
  logic        ps_to_fs_valid;
  logic [34:0] ps_to_fs_bus;
  logic        fs_allowin;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [66:0] fs_to_ds_bus;
  logic        handle_exc;
  logic        handle_eret;
  logic        pipe_flush;
`ifdef FS_PERF_CNT_EN
  logic [31:0] fs_stall_cnt;
`endif

  int tests;
  int fails;

  fs_stage #(.CANCEL_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .ps_to_fs_valid    (ps_to_fs_valid),
    .ps_to_fs_bus      (ps_to_fs_bus),
    .fs_allowin        (fs_allowin),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .ds_allowin        (ds_allowin),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .handle_exc        (handle_exc),
    .handle_eret       (handle_eret),
    .pipe_flush        (pipe_flush)
`ifdef FS_PERF_CNT_EN
    ,
    .fs_stall_cnt      (fs_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  // NOTE: stimulus uses blocking assignments from procedural code, away from the sampling edge.
  task automatic drive(input logic pv, input logic [34:0] b, input logic dok,
                       input logic [31:0] rd, input logic dsa, input logic fl);
    ps_to_fs_valid    = pv;
    ps_to_fs_bus      = b;
    inst_sram_data_ok = dok;
    inst_sram_rdata   = rd;
    ds_allowin        = dsa;
    pipe_flush        = fl;
    handle_exc        = 1'b0;
    handle_eret       = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if (fs_allowin !== 1'b1) begin
      fails++; $display("FAIL reset_allowin: got %b want 1", fs_allowin);
    end
    tests++;
    if (fs_to_ds_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", fs_to_ds_valid);
    end
`ifdef FS_PERF_CNT_EN
    tests++;
    if (fs_stall_cnt !== 32'd0) begin
      fails++; $display("FAIL reset_stall_cnt: got %0d want 0", fs_stall_cnt);
    end
`endif
    next_cycle();
  endtask

  task automatic test_basic_fetch();
    do_reset();
    drive(1'b1, {3'b000, 32'hbfc0_0000}, 1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_to_ds_valid !== 1'b0 || fs_allowin !== 1'b0) begin
      fails++; $display("FAIL basic_wait: valid=%b allowin=%b want 0/0", fs_to_ds_valid, fs_allowin);
    end
    next_cycle();
    drive(1'b0, '0, 1'b1, 32'h3c1d_0001, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {3'b000, 32'hbfc0_0000, 32'h3c1d_0001}) begin
      fails++; $display("FAIL basic_deliver: valid=%b bus=%h want 1 %h", fs_to_ds_valid, fs_to_ds_bus,
                        {3'b000, 32'hbfc0_0000, 32'h3c1d_0001});
    end
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_to_ds_valid !== 1'b0 || fs_allowin !== 1'b1) begin
      fails++; $display("FAIL basic_after: valid=%b allowin=%b want 0/1", fs_to_ds_valid, fs_allowin);
    end
    next_cycle();
  endtask

  task automatic test_ds_stall();
    logic [66:0] exp_bus;
    exp_bus = {3'b000, 32'hbfc0_0000, 32'h3c1d_0001};
    do_reset();
    drive(1'b1, {3'b000, 32'hbfc0_0000}, 1'b0, '0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      // Response only in the first stalled cycle; afterwards the latched word must hold.
      drive(1'b0, '0, (i == 0), (i == 0) ? 32'h3c1d_0001 : 32'hdead_beef, 1'b0, 1'b0);
      @(negedge clk);
      tests++;
      if (fs_to_ds_valid !== 1'b1 || fs_allowin !== 1'b0 || fs_to_ds_bus !== exp_bus) begin
        fails++; $display("FAIL stall_hold[%0d]: valid=%b allowin=%b bus=%h want 1 0 %h",
                          i, fs_to_ds_valid, fs_allowin, fs_to_ds_bus, exp_bus);
      end
      next_cycle();
    end
    drive(1'b0, '0, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_to_ds_valid !== 1'b1 || fs_allowin !== 1'b1 || fs_to_ds_bus !== exp_bus) begin
      fails++; $display("FAIL stall_release: valid=%b allowin=%b bus=%h want 1 1 %h",
                        fs_to_ds_valid, fs_allowin, fs_to_ds_bus, exp_bus);
    end
    next_cycle();
  endtask

  task automatic test_exception_entry();
    do_reset();
    drive(1'b1, {3'b100, 32'hbfc0_0002}, 1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, 32'hffff_ffff, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {3'b100, 32'hbfc0_0002, 32'h0}) begin
      fails++; $display("FAIL exc_entry: valid=%b bus=%h want 1 %h", fs_to_ds_valid, fs_to_ds_bus,
                        {3'b100, 32'hbfc0_0002, 32'h0});
    end
    tests++;
    if (dut.outstanding !== 2'd0) begin
      fails++; $display("FAIL exc_outstanding: got %0d want 0", dut.outstanding);
    end
    next_cycle();
  endtask

  task automatic test_flush_discard();
    do_reset();
    drive(1'b1, {3'b000, 32'hbfc0_0000}, 1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, {3'b000, 32'hbfc0_0380}, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_allowin !== 1'b1) begin
      fails++; $display("FAIL flush_allowin: got %b want 1", fs_allowin);
    end
    next_cycle();
    drive(1'b0, '0, 1'b1, 32'h0000_aaaa, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_to_ds_valid !== 1'b0) begin
      fails++; $display("FAIL flush_drop: valid=%b want 0", fs_to_ds_valid);
    end
    next_cycle();
    drive(1'b0, '0, 1'b1, 32'h0000_bbbb, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {3'b000, 32'hbfc0_0380, 32'h0000_bbbb}) begin
      fails++; $display("FAIL flush_refill: valid=%b bus=%h want 1 %h", fs_to_ds_valid, fs_to_ds_bus,
                        {3'b000, 32'hbfc0_0380, 32'h0000_bbbb});
    end
    next_cycle();
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    drive(1'b1, {3'b000, 32'h8000_0100}, 1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b1, 32'h1111_1111, 1'b1, 1'b1);
    @(negedge clk);
    tests++;
    if (fs_to_ds_valid !== 1'b0) begin
      fails++; $display("FAIL same_flush_valid: got %b want 0", fs_to_ds_valid);
    end
    next_cycle();
    drive(1'b1, {3'b000, 32'h8000_0200}, 1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (dut.discard !== 2'd0) begin
      fails++; $display("FAIL same_flush_discard: got %0d want 0", dut.discard);
    end
    next_cycle();
    drive(1'b0, '0, 1'b1, 32'h2222_2222, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {3'b000, 32'h8000_0200, 32'h2222_2222}) begin
      fails++; $display("FAIL same_flush_next: valid=%b bus=%h want 1 %h", fs_to_ds_valid, fs_to_ds_bus,
                        {3'b000, 32'h8000_0200, 32'h2222_2222});
    end
    next_cycle();
  endtask

`ifdef FS_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    drive(1'b1, {3'b000, 32'hbfc0_0000}, 1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    repeat (4) next_cycle();
    drive(1'b0, '0, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_stall_cnt !== 32'd4) begin
      fails++; $display("FAIL perf_wait: got %0d want 4", fs_stall_cnt);
    end
    next_cycle();
    drive(1'b1, {3'b000, 32'hbfc0_0004}, 1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, '0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (fs_stall_cnt !== 32'd4 || fs_to_ds_valid !== 1'b0) begin
      fails++; $display("FAIL perf_flush: cnt=%0d valid=%b want 4 0", fs_stall_cnt, fs_to_ds_valid);
    end
    next_cycle();
  endtask
`endif

  task automatic test_random();
    bit          inflight[$];   // one entry per pending request: 1 = squashed
    logic        m_valid, m_inst_ok;
    logic [34:0] m_bus;
    logic [31:0] m_inst;
    logic        pv, dok, dsa, fl, front_live, ready, e_allow, e_valid, ex;
    logic [2:0]  flags;
    logic [31:0] pc, rd;
    logic [66:0] e_bus;
    int          src;

    do_reset();
    m_valid = 1'b0; m_inst_ok = 1'b0; m_bus = '0; m_inst = '0;
    for (int c = 0; c < 3000; c++) begin
      pv    = ($urandom_range(0, 9) < 6) && (inflight.size() < 3);
      flags = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      pc    = $urandom;
      dok   = (inflight.size() > 0) && ($urandom_range(0, 9) < 4);
      rd    = $urandom;
      dsa   = $urandom_range(0, 9) < 7;
      fl    = $urandom_range(0, 19) == 0;
      src   = $urandom_range(0, 2);

      drive(pv, {flags, pc}, dok, rd, dsa, 1'b0);
      handle_exc  = fl && (src == 0);
      handle_eret = fl && (src == 1);
      pipe_flush  = fl && (src == 2);

      front_live = dok && !inflight[0];
      ready      = m_inst_ok || front_live;
      e_allow    = !m_valid || (ready && dsa);
      e_valid    = m_valid && ready && !fl;
      e_bus      = {m_bus, m_inst_ok ? m_inst : rd};

      @(negedge clk);
      tests++;
      if (fs_allowin !== e_allow) begin
        fails++; $display("FAIL rnd_allowin @%0d: got %b want %b", c, fs_allowin, e_allow);
      end
      tests++;
      if (fs_to_ds_valid !== e_valid) begin
        fails++; $display("FAIL rnd_valid @%0d: got %b want %b", c, fs_to_ds_valid, e_valid);
      end
      if (e_valid) begin
        tests++;
        if (fs_to_ds_bus !== e_bus) begin
          fails++; $display("FAIL rnd_bus @%0d: got %h want %h", c, fs_to_ds_bus, e_bus);
        end
      end

      ex = |flags;
      if (dok) void'(inflight.pop_front());
      if (pv && e_allow && !ex) inflight.push_back(1'b0);
      if (fl) begin
        foreach (inflight[i]) inflight[i] = 1'b1;
        m_valid   = 1'b0;
        m_inst_ok = 1'b0;
      end else if (e_allow) begin
        m_valid = pv;
        if (pv) begin
          m_bus     = {flags, pc};
          m_inst    = '0;
          m_inst_ok = ex;
        end
      end else if (front_live) begin
        m_inst    = rd;
        m_inst_ok = 1'b1;
      end
      next_cycle();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_fetch();
    test_ds_stall();
    test_exception_entry();
    test_flush_discard();
    test_flush_same_cycle();
`ifdef FS_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
